// File: rtl/flash_boot_loader.sv
// Boot-time loader: reads an image from SPI flash (READ 0x03, mode 0) and writes it
// byte by byte into SRAM, holding the 6502 in reset until the copy is complete.
module flash_boot_loader #(
    parameter logic [23:0] FLASH_ADDR = 24'h000000,
    parameter logic [18:0] LOAD_ADDR  = 19'h7F000,
    parameter int unsigned LENGTH     = 4096,
    parameter int unsigned SCK_DIV    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        flash_cs_n,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic [18:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        cpu_reset
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int CNT_W = (LENGTH > 0) ? $clog2(LENGTH + 1) : 1;
    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

    state_t             state_q;
    state_t             state_d;
    logic               sck_q;
    logic [DIV_W-1:0]   div_cnt;
    logic [4:0]         bit_cnt;
    logic [4:0]         phase_last;
    logic [31:0]        tx_shift;
    logic [7:0]         rx_shift;
    logic [CNT_W-1:0]   byte_cnt;
    logic               shifting;
    logic               div_tc;
    logic               sck_rise;
    logic               sck_fall;
    logic               phase_end;
    logic               last_byte;

    assign shifting  = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign div_tc    = shifting && (div_cnt == DIV_LAST);
    assign sck_rise  = div_tc && !sck_q;
    assign sck_fall  = div_tc && sck_q;
    assign phase_end = sck_fall && (bit_cnt == phase_last);
    assign last_byte = (byte_cnt == LAST_CNT);
    assign flash_sck = sck_q;

    // A phase ends on the falling SCK edge of its final bit, so SCK is already low on entry to WRITE.
    always_comb begin
        phase_last = 5'd7;
        if (state_q == S_ADDR) phase_last = 5'd23;
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = (LENGTH > 0) ? S_CMD : S_DONE;
            S_CMD:   if (phase_end) state_d = S_ADDR;
            S_ADDR:  if (phase_end) state_d = S_DATA;
            S_DATA:  if (phase_end) state_d = S_WRITE;
            S_WRITE: if (mem_ready) state_d = last_byte ? S_DONE : S_DATA;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sck_q    <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            byte_cnt <= '0;
            mem_addr <= LOAD_ADDR;
            mem_data <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                tx_shift <= {8'h03, FLASH_ADDR};
            end
            // Outside CMD/ADDR/DATA the divider idles at zero, so SCK stays low through WRITE.
            if (shifting) begin
                div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
                if (div_tc)   sck_q    <= ~sck_q;
                if (sck_rise) rx_shift <= {rx_shift[6:0], flash_miso};
                if (sck_fall) begin
                    tx_shift <= {tx_shift[30:0], 1'b0};
                    bit_cnt  <= phase_end ? '0 : bit_cnt + 1'b1;
                end
                if (phase_end && state_q == S_DATA) mem_data <= rx_shift;
            end
            if (state_q == S_WRITE && mem_ready) begin
                mem_addr <= mem_addr + 1'b1;
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        flash_cs_n = 1'b1;
        flash_mosi = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cpu_reset  = 1'b1;
        unique case (state_q)
            S_CMD, S_ADDR: begin
                flash_cs_n = 1'b0;
                flash_mosi = tx_shift[31];
                busy       = 1'b1;
            end
            S_DATA: begin
                flash_cs_n = 1'b0;
                busy       = 1'b1;
            end
            S_WRITE: begin
                flash_cs_n = 1'b0;
                mem_we     = 1'b1;
                busy       = 1'b1;
            end
            S_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Self-checking bench for flash_boot_loader: three instances (nominal, address wrap,
// zero length) share one behavioural SPI flash and a table of expected SRAM writes.
module tb_flash_boot_loader;

    localparam int DIV_A = 2;
    localparam int DIV_B = 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic mem_ready = 1'b0;
    logic spi_miso = 1'b0;

    logic        cs_n_a, sck_a, mosi_a, we_a, busy_a, done_a, cpur_a;
    logic        cs_n_b, sck_b, mosi_b, we_b, busy_b, done_b, cpur_b;
    logic        cs_n_c, sck_c, mosi_c, we_c, busy_c, done_c, cpur_c;
    logic [18:0] addr_a, addr_b, addr_c;
    logic [7:0]  data_a, data_b, data_c;

    always #5 clock = ~clock;

    flash_boot_loader #(.FLASH_ADDR(24'h000000), .LOAD_ADDR(19'h7F000), .LENGTH(4), .SCK_DIV(DIV_A)) dut_a (
        .clock(clock), .reset(reset), .start(start_a),
        .flash_cs_n(cs_n_a), .flash_sck(sck_a), .flash_mosi(mosi_a), .flash_miso(spi_miso),
        .mem_addr(addr_a), .mem_data(data_a), .mem_we(we_a), .mem_ready(mem_ready),
        .busy(busy_a), .done(done_a), .cpu_reset(cpur_a));

    flash_boot_loader #(.FLASH_ADDR(24'h123456), .LOAD_ADDR(19'h7FFFE), .LENGTH(4), .SCK_DIV(DIV_B)) dut_b (
        .clock(clock), .reset(reset), .start(start_b),
        .flash_cs_n(cs_n_b), .flash_sck(sck_b), .flash_mosi(mosi_b), .flash_miso(spi_miso),
        .mem_addr(addr_b), .mem_data(data_b), .mem_we(we_b), .mem_ready(mem_ready),
        .busy(busy_b), .done(done_b), .cpu_reset(cpur_b));

    flash_boot_loader #(.FLASH_ADDR(24'h000000), .LOAD_ADDR(19'h7F000), .LENGTH(0), .SCK_DIV(DIV_A)) dut_c (
        .clock(clock), .reset(reset), .start(start_c),
        .flash_cs_n(cs_n_c), .flash_sck(sck_c), .flash_mosi(mosi_c), .flash_miso(spi_miso),
        .mem_addr(addr_c), .mem_data(data_c), .mem_we(we_c), .mem_ready(mem_ready),
        .busy(busy_c), .done(done_c), .cpu_reset(cpur_c));

    // Only one instance is ever active, so idle buses (cs_n=1, sck=0, mosi=0) merge cleanly.
    logic spi_cs_n, spi_sck, spi_mosi;
    assign spi_cs_n = cs_n_a & cs_n_b & cs_n_c;
    assign spi_sck  = sck_a | sck_b | sck_c;
    assign spi_mosi = mosi_a | mosi_b | mosi_c;

    int          cur = 0;
    logic        sel_cs_n, sel_sck, sel_we, sel_busy, sel_done, sel_cpur;
    logic [18:0] sel_addr;
    logic [7:0]  sel_data;

    always_comb begin
        sel_cs_n = cs_n_c; sel_sck = sck_c; sel_we = we_c; sel_busy = busy_c;
        sel_done = done_c; sel_cpur = cpur_c; sel_addr = addr_c; sel_data = data_c;
        if (cur == 0) begin
            sel_cs_n = cs_n_a; sel_sck = sck_a; sel_we = we_a; sel_busy = busy_a;
            sel_done = done_a; sel_cpur = cpur_a; sel_addr = addr_a; sel_data = data_a;
        end else if (cur == 1) begin
            sel_cs_n = cs_n_b; sel_sck = sck_b; sel_we = we_b; sel_busy = busy_b;
            sel_done = done_b; sel_cpur = cpur_b; sel_addr = addr_b; sel_data = data_b;
        end
    end

    // Behavioural flash: captures the 32-bit header, then streams image bytes (aliased every 8 bytes).
    logic [7:0]  image [8];
    logic [31:0] hdr = '0;
    int          hdr_bits = 0;
    int          dbits = 0;
    int          mosi_bad = 0;
    logic        sck_prev = 1'b0;
    logic [23:0] fa;
    logic [7:0]  fbyte;

    always @(spi_cs_n, spi_sck) begin
        if (spi_cs_n) begin
            hdr = '0; hdr_bits = 0; dbits = 0; spi_miso = 1'b0;
        end else if (spi_sck && !sck_prev) begin
            if (hdr_bits < 32) begin
                hdr = {hdr[30:0], spi_mosi};
                hdr_bits++;
            end else if (spi_mosi !== 1'b0) begin
                mosi_bad++;
            end
        end else if (!spi_sck && sck_prev && hdr_bits == 32) begin
            fa       = hdr[23:0] + 24'(dbits / 8);
            fbyte    = image[fa[2:0]];
            spi_miso = fbyte[7 - (dbits % 8)];
            dbits++;
        end
        sck_prev = spi_sck;
    end

    logic c_low_seen = 1'b0;
    always @(negedge clock) if (!cs_n_c) c_low_seen = 1'b1;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int dut, input logic v);
        if (dut == 0)      start_a = v;
        else if (dut == 1) start_b = v;
        else               start_c = v;
    endtask

    task automatic pulse_start(input int dut);
        set_start(dut, 1'b1);
        @(negedge clock);
        set_start(dut, 1'b0);
    endtask

    // Counts negedges until mem_we; optionally pokes start 5 clocks in (must be ignored).
    task automatic wait_we(input int dut, input bit poke, output int lat);
        lat = 0;
        while (!sel_we && lat < 1000) begin
            @(negedge clock);
            lat++;
            set_start(dut, poke && lat == 5);
        end
        set_start(dut, 1'b0);
    endtask

    typedef struct {
        int          dut;
        bit          first;
        bit          poke;
        int          stall;
        logic [18:0] addr;
        logic [7:0]  data;
    } vec_t;

    vec_t vecs[12];

    function automatic int div_of(input int dut);
        return (dut == 1) ? DIV_B : DIV_A;
    endfunction

    function automatic logic [23:0] fa_of(input int dut);
        return (dut == 1) ? 24'h123456 : 24'h000000;
    endfunction

    task automatic apply(input int lo, input int hi);
        int lat;
        int exp_lat;
        for (int i = lo; i <= hi; i++) begin
            cur = vecs[i].dut;
            if (vecs[i].first) begin
                pulse_start(vecs[i].dut);
                check("cs_fall_busy", {sel_cs_n, sel_busy, sel_cpur}, 3'b011);
                exp_lat = 80 * div_of(vecs[i].dut);
            end else begin
                exp_lat = 16 * div_of(vecs[i].dut);
            end
            wait_we(vecs[i].dut, vecs[i].poke, lat);
            check("we_latency", lat, exp_lat);
            if (vecs[i].first) check("header", hdr, {8'h03, fa_of(vecs[i].dut)});
            check("wr_addr", sel_addr, vecs[i].addr);
            check("wr_data", sel_data, vecs[i].data);
            for (int s = 0; s < vecs[i].stall; s++) begin
                @(negedge clock);
                check("stall_hold", {sel_we, sel_sck, sel_cs_n, sel_addr, sel_data},
                      {1'b1, 1'b0, 1'b0, vecs[i].addr, vecs[i].data});
            end
            mem_ready = 1'b1;
            @(negedge clock);
            mem_ready = 1'b0;
            check("we_drop", {sel_we, sel_sck, sel_addr}, {1'b0, 1'b0, vecs[i].addr + 19'd1});
            if (i == hi || vecs[i+1].first)
                check("done_state", {sel_done, sel_cpur, sel_cs_n, sel_busy}, 4'b1010);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        int lat;
        image = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h3C, 8'hC3, 8'h81, 8'h7E};
        vecs[0]  = '{0, 1'b1, 1'b1, 0, 19'h7F000, 8'hA5};
        vecs[1]  = '{0, 1'b0, 1'b1, 0, 19'h7F001, 8'h5A};
        vecs[2]  = '{0, 1'b0, 1'b1, 0, 19'h7F002, 8'h00};
        vecs[3]  = '{0, 1'b0, 1'b0, 0, 19'h7F003, 8'hFF};
        vecs[4]  = '{1, 1'b1, 1'b0, 0, 19'h7FFFE, 8'h81};
        vecs[5]  = '{1, 1'b0, 1'b0, 0, 19'h7FFFF, 8'h7E};
        vecs[6]  = '{1, 1'b0, 1'b0, 0, 19'h00000, 8'hA5};
        vecs[7]  = '{1, 1'b0, 1'b0, 0, 19'h00001, 8'h5A};
        vecs[8]  = '{0, 1'b1, 1'b0, 0, 19'h7F000, 8'hA5};
        vecs[9]  = '{0, 1'b0, 1'b0, 5, 19'h7F001, 8'h5A};
        vecs[10] = '{0, 1'b0, 1'b0, 0, 19'h7F002, 8'h00};
        vecs[11] = '{0, 1'b0, 1'b0, 0, 19'h7F003, 8'hFF};

        // Start coincident with reset must be ignored.
        repeat (2) @(negedge clock);
        start_c = 1'b1;
        @(negedge clock);
        start_c = 1'b0;
        reset   = 1'b0;
        @(negedge clock);
        check("rst_outs_a", {cs_n_a, sck_a, mosi_a, we_a, busy_a, done_a, cpur_a}, 7'b1000001);
        check("rst_addr_a", addr_a, 19'h7F000);
        check("rst_data_a", data_a, 8'h00);
        check("rst_addr_b", addr_b, 19'h7FFFE);
        check("start_in_rst", {done_c, cpur_c, cs_n_c}, 3'b011);

        // Zero-length image: done one clock after start, chip select never asserted.
        cur = 2;
        pulse_start(2);
        check("len0_done", {done_c, cpur_c, busy_c, cs_n_c}, 4'b1001);

        apply(0, 7);

        // Start in DONE has no effect.
        cur = 0;
        pulse_start(0);
        repeat (3) @(negedge clock);
        check("start_in_done", {cs_n_a, done_a, cpur_a, busy_a}, 4'b1100);

        // Reset in the middle of the second data byte.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        pulse_start(0);
        wait_we(0, 1'b0, lat);
        check("t3_first_we", lat, 80 * DIV_A);
        mem_ready = 1'b1;
        @(negedge clock);
        mem_ready = 1'b0;
        repeat (10) @(negedge clock);
        check("t3_in_data", {busy_a, we_a, cs_n_a}, 3'b100);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t3_rst_outs", {cs_n_a, sck_a, we_a, busy_a, done_a, cpur_a}, 6'b100001);
        check("t3_rst_addr", addr_a, 19'h7F000);
        check("t3_rst_data", data_a, 8'h00);

        apply(8, 11);

        check("mosi_zero_in_data", mosi_bad, 0);
        check("len0_cs_never_low", c_low_seen, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
